writeback_stage: RTL and testbench
==================================

# writeback_stage

Final stage of the RV32I five-stage pipeline. Registers the memory-stage results into the writeback pipeline register and selects the result: ALU output, load data (byte/halfword extracted and extended), or PC+4. Drives the register-file write port (`addr_3`, `we`, `wd_3`), the same port whose read side feeds the decode stage. Also exports writeback-stage forwarding signals and, optionally, a retired-instruction counter.

## Interface
- `ADW`, 5, register address width
- `DPW`, from `rv32i_pkg`, datapath width (32); not overridable here
- `clk` in 1: clock
- `rst_n` in 1: reset, synchronous, active-low
- `validM` in 1: memory-stage slot holds a real instruction
- `stallW` in 1: hold the writeback register
- `flushW` in 1: replace the writeback register contents with a bubble
- `regwriteM` in 1: instruction writes rd
- `resultsrcM` in 2: 00 ALU, 01 load, 10 PC+4, 11 treated as ALU
- `funct3M` in 3: load width/sign
- `aluresultM` in DPW: ALU result, also the load address
- `readdataM` in DPW: raw 32-bit data-memory word
- `pcplus4M` in DPW: PC+4 of the instruction
- `RdM` in ADW: destination register
- `addr_3` out ADW: register-file write address
- `we` out 1: register-file write enable
- `wd_3` out DPW: register-file write data
- `RdW` out ADW: forwarding destination
- `regwriteW` out 1: forwarding qualifier, equal to `we`
- `resultW` out DPW: forwarding data, equal to `wd_3`
- `validW` out 1: writeback slot valid
- `instret` out 64: retired-instruction count (only with `WB_INSTRET_EN`)

## Operation
- W register fields: `valid`, `regwrite`, `resultsrc`, `funct3`, `aluresult`, `readdata`, `pcplus4`, `rd`.
- Update priority on each rising edge of `clk`:
  - `!rst_n`: all fields cleared.
  - Else if `flushW`: `valid`=0 and `regwrite`=0; data fields don't-care.
  - Else if `stallW`: hold all fields.
  - Else: load all fields from the M inputs.
- Result select, combinational from the W register:
  - `resultsrc`=10: `pcplus4`.
  - `resultsrc`=01: load extraction (below).
  - Otherwise: `aluresult`.
- Load extraction. Byte offset `off = aluresult[1:0]`. Halfword select uses `aluresult[1]` only; bit 0 is ignored, with no misalignment trap.
  - `funct3`=000 LB: sign-extend byte `off`.
  - 100 LBU: zero-extend byte `off`.
  - 001 LH: sign-extend halfword `aluresult[1]`.
  - 101 LHU: zero-extend halfword `aluresult[1]`.
  - 010 LW, and any other code: full word.
- Register-file write port:
  - `we = valid & regwrite & (rd != 0)`.
  - `addr_3 = rd`.
  - `wd_3` = the selected result.
  - Writes to x0 are suppressed here.
- Forwarding outputs:
  - `RdW = rd`, `regwriteW = we`, `resultW = wd_3`.
  - Consumers compare `RdW` and need no separate x0 check.
- While stalled, `we` stays asserted with the same address and data. The repeated write is idempotent.

## Timing
- Latency: M inputs are visible on `wd_3`/`we` one cycle after capture. The register file commits at the following rising edge.
- All outputs are combinational from the W register. There is no combinational path from M inputs to any output.
- Reset values: `addr_3`=0, `we`=0, `wd_3`=0, `RdW`=0, `regwriteW`=0, `resultW`=0, `validW`=0, `instret`=0.
- Simultaneous `flushW` and `stallW`: flush wins, and the slot becomes a bubble.
- Reset asserted mid-stall: the W register clears at the next edge regardless of `stallW`/`flushW`.
- `validM`=0 with `regwriteM`=1 is captured, but `we` stays 0.

## Configuration
- Macro: `WB_INSTRET_EN`.
- Defined:
  - 64-bit `instret` register.
  - Cleared by reset.
  - Increments by 1 on each edge where the W register loads with `validM`=1, `!flushW` and `!stallW`. Each instruction counts exactly once, however long it is stalled.
  - Wraps from 2^64−1 to 0.
- Not defined: `instret` port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then ALU op with `RdM`=5, `aluresultM`=0x1234_5678, `resultsrcM`=00, `validM`=1, `regwriteM`=1. One cycle later: `we`=1, `addr_3`=5, `wd_3`=0x1234_5678.
- `readdataM`=0x80FF_7F01, `resultsrcM`=01, `aluresultM[1:0]`=3:
  - LB gives 0xFFFF_FF80.
  - LBU gives 0x0000_0080.
  - LH with `aluresultM[1]`=1 gives 0xFFFF_80FF.
  - LHU gives 0x0000_80FF.
- Write to `RdM`=0 with `regwriteM`=1 and `validM`=1: `we`=0, `regwriteW`=0.
- `resultsrcM`=10, `pcplus4M`=0x0000_0104: `wd_3`=0x0000_0104. Then `stallW` held 3 cycles: outputs unchanged and `instret` increments once.
- Load a valid instruction, then assert `flushW` and `stallW` together: next cycle `validW`=0, `we`=0. Assert `rst_n`=0 during a stall: all outputs 0 the next cycle.
- With `WB_INSTRET_EN`: 10 valid instructions interleaved with 4 bubbles and 2 flushed slots give `instret`=10.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: final stage of the RV32I five-stage pipeline.
// Captures the memory-stage results into the W pipeline register, selects the
// writeback result (ALU, extracted load data, or PC+4) and drives the
// register-file write port plus the writeback forwarding signals.
// Optional feature: define WB_INSTRET_EN to add a 64-bit retired-instruction
// counter on the instret output port.

package rv32i_pkg;
  localparam int DPW = 32;
endpackage

module writeback_stage
  import rv32i_pkg::*;
#(
  parameter int ADW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           validM,
  input  logic           stallW,
  input  logic           flushW,
  input  logic           regwriteM,
  input  logic [1:0]     resultsrcM,
  input  logic [2:0]     funct3M,
  input  logic [DPW-1:0] aluresultM,
  input  logic [DPW-1:0] readdataM,
  input  logic [DPW-1:0] pcplus4M,
  input  logic [ADW-1:0] RdM,
  output logic [ADW-1:0] addr_3,
  output logic           we,
  output logic [DPW-1:0] wd_3,
  output logic [ADW-1:0] RdW,
  output logic           regwriteW,
  output logic [DPW-1:0] resultW,
  output logic           validW
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]    instret
`endif
);

  // W pipeline register fields
  logic           valid_q;
  logic           regwrite_q;
  logic [1:0]     resultsrc_q;
  logic [2:0]     funct3_q;
  logic [DPW-1:0] aluresult_q;
  logic [DPW-1:0] readdata_q;
  logic [DPW-1:0] pcplus4_q;
  logic [ADW-1:0] rd_q;

  // Combinational datapath
  logic [7:0]     load_byte;
  logic [15:0]    load_half;
  logic [DPW-1:0] load_data;
  logic [DPW-1:0] result;

  // W register update: reset beats flush, flush beats stall, else capture M.
  // A flush only kills the control bits; the data fields are left as they are
  // because nothing observes them while valid/regwrite are low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      resultsrc_q <= 2'b00;
      funct3_q    <= 3'b000;
      aluresult_q <= '0;
      readdata_q  <= '0;
      pcplus4_q   <= '0;
      rd_q        <= '0;
    end else if (flushW) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (!stallW) begin
      valid_q     <= validM;
      regwrite_q  <= regwriteM;
      resultsrc_q <= resultsrcM;
      funct3_q    <= funct3M;
      aluresult_q <= aluresultM;
      readdata_q  <= readdataM;
      pcplus4_q   <= pcplus4M;
      rd_q        <= RdM;
    end
  end

  // Load extraction: byte lane from addr[1:0], halfword lane from addr[1]
  // only (addr[0] ignored, misaligned halfwords are not trapped here).
  always_comb begin
    load_byte = readdata_q[7:0];
    case (aluresult_q[1:0])
      2'd0: load_byte = readdata_q[7:0];
      2'd1: load_byte = readdata_q[15:8];
      2'd2: load_byte = readdata_q[23:16];
      2'd3: load_byte = readdata_q[31:24];
      default: load_byte = readdata_q[7:0];
    endcase
    load_half = aluresult_q[1] ? readdata_q[31:16] : readdata_q[15:0];
    case (funct3_q)
      3'b000:  load_data = {{(DPW-8){load_byte[7]}}, load_byte};
      3'b100:  load_data = {{(DPW-8){1'b0}}, load_byte};
      3'b001:  load_data = {{(DPW-16){load_half[15]}}, load_half};
      3'b101:  load_data = {{(DPW-16){1'b0}}, load_half};
      default: load_data = readdata_q;
    endcase
  end

  // Result select; code 11 falls through to the ALU result.
  always_comb begin
    case (resultsrc_q)
      2'b10:   result = pcplus4_q;
      2'b01:   result = load_data;
      default: result = aluresult_q;
    endcase
  end

  // Register-file port and forwarding share one qualified write enable, so
  // x0 writes are dropped here and consumers need no x0 check of their own.
  assign we        = valid_q & regwrite_q & (rd_q != '0);
  assign addr_3    = rd_q;
  assign wd_3      = result;
  assign RdW       = rd_q;
  assign regwriteW = we;
  assign resultW   = result;
  assign validW    = valid_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // Count each instruction once, on the edge that moves it into W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_q <= 64'd0;
    end else if (validM && !flushW && !stallW) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed, table-driven bench for writeback_stage with
// hand-written sequences for stall, flush+stall, reset-mid-stall and the
// optional retired-instruction counter (WB_INSTRET_EN).

module tb_writeback_stage;

  localparam logic [31:0] RDATA = 32'h80FF_7F01;
  localparam logic [31:0] PC4   = 32'h0000_0104;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        validM, stallW, flushW, regwriteM;
  logic [1:0]  resultsrcM;
  logic [2:0]  funct3M;
  logic [31:0] aluresultM, readdataM, pcplus4M;
  logic [4:0]  RdM;
  logic [4:0]  addr_3, RdW;
  logic        we, regwriteW, validW;
  logic [31:0] wd_3, resultW;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
  logic [63:0] exp_instret;
  logic [63:0] held_instret;
`endif

  always #5 clk = ~clk;

  writeback_stage #(.ADW(5)) dut (
    .clk(clk), .rst_n(rst_n), .validM(validM), .stallW(stallW),
    .flushW(flushW), .regwriteM(regwriteM), .resultsrcM(resultsrcM),
    .funct3M(funct3M), .aluresultM(aluresultM), .readdataM(readdataM),
    .pcplus4M(pcplus4M), .RdM(RdM), .addr_3(addr_3), .we(we), .wd_3(wd_3),
    .RdW(RdW), .regwriteW(regwriteW), .resultW(resultW), .validW(validW)
`ifdef WB_INSTRET_EN
    , .instret(instret)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Check every output against expected W-slot contents.
  task automatic check_outs(input string tag, input logic ev, input logic ewe,
                            input logic [4:0] erd, input logic [31:0] ewd);
    check({tag, " validW"},    {63'd0, validW},    {63'd0, ev});
    check({tag, " we"},        {63'd0, we},        {63'd0, ewe});
    check({tag, " regwriteW"}, {63'd0, regwriteW}, {63'd0, ewe});
    check({tag, " addr_3"},    {59'd0, addr_3},    {59'd0, erd});
    check({tag, " RdW"},       {59'd0, RdW},       {59'd0, erd});
    check({tag, " wd_3"},      {32'd0, wd_3},      {32'd0, ewd});
    check({tag, " resultW"},   {32'd0, resultW},   {32'd0, ewd});
  endtask

  // ---------------- driver tasks ----------------
  // One clock: predict the counter from the inputs about to be sampled, then
  // return #1 after the edge so outputs are stable for checking.
  task automatic step();
`ifdef WB_INSTRET_EN
    if (!rst_n) exp_instret = 64'd0;
    else if (validM && !flushW && !stallW) exp_instret = exp_instret + 64'd1;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [4:0] rd);
    validM = v; regwriteM = rw; resultsrcM = src; funct3M = f3;
    aluresultM = alu; readdataM = RDATA; pcplus4M = pc4; RdM = rd;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic        rw;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic v, input logic rw, input logic [1:0] src,
                              input logic [2:0] f3, input logic [31:0] alu,
                              input logic [4:0] rd, input logic ewe,
                              input logic [31:0] ewd);
    vec_t t;
    t.v = v; t.rw = rw; t.src = src; t.f3 = f3; t.alu = alu; t.rd = rd;
    t.exp_we = ewe; t.exp_wd = ewd;
    return t;
  endfunction

  // Load-sequence pattern for the counter test: 0 valid, 1 bubble, 2 flushed.
  int pat[16] = '{0, 1, 0, 0, 2, 0, 1, 0, 0, 1, 2, 0, 0, 1, 0, 0};

  initial begin
    // readdata 0x80FF7F01: byte0=01 byte1=7F byte2=FF byte3=80
    vecs[0]  = mk(1, 1, 2'b00, 3'b000, 32'h1234_5678, 5'd5,  1, 32'h1234_5678);
    vecs[1]  = mk(1, 1, 2'b01, 3'b000, 32'h0000_2003, 5'd6,  1, 32'hFFFF_FF80);
    vecs[2]  = mk(1, 1, 2'b01, 3'b100, 32'h0000_2003, 5'd6,  1, 32'h0000_0080);
    vecs[3]  = mk(1, 1, 2'b01, 3'b001, 32'h0000_2003, 5'd6,  1, 32'hFFFF_80FF);
    vecs[4]  = mk(1, 1, 2'b01, 3'b101, 32'h0000_2003, 5'd6,  1, 32'h0000_80FF);
    vecs[5]  = mk(1, 1, 2'b01, 3'b000, 32'h0000_2001, 5'd8,  1, 32'h0000_007F);
    vecs[6]  = mk(1, 1, 2'b01, 3'b000, 32'h0000_2002, 5'd8,  1, 32'hFFFF_FFFF);
    vecs[7]  = mk(1, 1, 2'b01, 3'b100, 32'h0000_2000, 5'd8,  1, 32'h0000_0001);
    vecs[8]  = mk(1, 1, 2'b01, 3'b001, 32'h0000_2001, 5'd8,  1, 32'h0000_7F01);
    vecs[9]  = mk(1, 1, 2'b01, 3'b101, 32'h0000_2002, 5'd8,  1, 32'h0000_80FF);
    vecs[10] = mk(1, 1, 2'b01, 3'b010, 32'h0000_2000, 5'd10, 1, 32'h80FF_7F01);
    vecs[11] = mk(1, 1, 2'b01, 3'b111, 32'h0000_2000, 5'd10, 1, 32'h80FF_7F01);
    vecs[12] = mk(1, 1, 2'b00, 3'b000, 32'hDEAD_0000, 5'd0,  0, 32'hDEAD_0000);
    vecs[13] = mk(0, 1, 2'b00, 3'b000, 32'h0000_0055, 5'd7,  0, 32'h0000_0055);
    vecs[14] = mk(1, 1, 2'b11, 3'b000, 32'hCAFE_F00D, 5'd31, 1, 32'hCAFE_F00D);
    vecs[15] = mk(1, 1, 2'b10, 3'b000, 32'hCAFE_F00D, 5'd1,  1, PC4);
    vecs[16] = mk(1, 0, 2'b00, 3'b000, 32'h0000_0099, 5'd9,  0, 32'h0000_0099);

    // reset
    rst_n = 1'b0; stallW = 1'b0; flushW = 1'b0;
    drive(0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
`ifdef WB_INSTRET_EN
    exp_instret = 64'd0;
`endif
    step(); step();
    check_outs("reset", 0, 0, 5'd0, 32'h0);
`ifdef WB_INSTRET_EN
    check("reset instret", instret, 64'd0);
`endif
    rst_n = 1'b1;

    // table: one capture per vector, visible right after the edge
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].src, vecs[i].f3, vecs[i].alu, PC4, vecs[i].rd);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].v, vecs[i].exp_we, vecs[i].rd, vecs[i].exp_wd);
`ifdef WB_INSTRET_EN
      check($sformatf("vec%0d instret", i), instret, exp_instret);
`endif
    end

    // PC+4 then 3-cycle stall while the M inputs change underneath
    drive(1, 1, 2'b10, 3'b000, 32'h0000_0AAA, PC4, 5'd1);
    step();
    check_outs("pc4 capture", 1, 1, 5'd1, PC4);
`ifdef WB_INSTRET_EN
    held_instret = instret;
`endif
    stallW = 1'b1;
    drive(1, 1, 2'b00, 3'b000, 32'h0000_0BAD, PC4, 5'd3);
    for (int c = 0; c < 3; c++) begin
      step();
      check_outs($sformatf("stall%0d", c), 1, 1, 5'd1, PC4);
`ifdef WB_INSTRET_EN
      check($sformatf("stall%0d instret", c), instret, held_instret);
`endif
    end
    stallW = 1'b0;
    step();
    check_outs("stall release", 1, 1, 5'd3, 32'h0000_0BAD);

    // flush and stall together: flush wins
    drive(1, 1, 2'b00, 3'b000, 32'h0000_0123, PC4, 5'd4);
    step();
    check_outs("pre flush", 1, 1, 5'd4, 32'h0000_0123);
    flushW = 1'b1; stallW = 1'b1;
    step();
    check("flush+stall validW", {63'd0, validW}, 64'd0);
    check("flush+stall we", {63'd0, we}, 64'd0);
    check("flush+stall regwriteW", {63'd0, regwriteW}, 64'd0);
    flushW = 1'b0; stallW = 1'b0;

    // reset asserted in the middle of a stall
    drive(1, 1, 2'b00, 3'b000, 32'h0000_0777, PC4, 5'd12);
    step();
    stallW = 1'b1;
    step();
    check_outs("held before reset", 1, 1, 5'd12, 32'h0000_0777);
    rst_n = 1'b0;
    step();
    check_outs("reset mid stall", 0, 0, 5'd0, 32'h0);
`ifdef WB_INSTRET_EN
    check("reset mid stall instret", instret, 64'd0);
`endif
    rst_n = 1'b1; stallW = 1'b0;

    // 10 valid, 4 bubbles, 2 flushed slots
    for (int k = 0; k < 16; k++) begin
      flushW = (pat[k] == 2);
      drive(pat[k] != 1, 1, 2'b00, 3'b000, 32'h100 + k, PC4, 5'd2);
      step();
    end
    flushW = 1'b0;
    check_outs("count seq last", 1, 1, 5'd2, 32'h0000_010F);
`ifdef WB_INSTRET_EN
    check("instret count", instret, 64'd10);
`endif

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
